// File: rtl/recip_lut_div_arbiter_if.sv
// Request/result bundle for the shared reciprocal-divide block.
// Requesters present packed per-lane operands. The block returns one tagged
// quotient stream with valid/ready flow control.
interface recip_lut_div_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DIV_W = 16,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*DIV_W-1:0] req_dividend;
  logic [N_REQ*8-1:0]     req_divisor_m1;
  logic                   out_valid;
  logic                   out_ready;
  logic [DIV_W-1:0]       out_quotient;
  logic [ID_W-1:0]        out_id;

  // Requester side plus the downstream consumer.
  modport master (
    output req_valid, req_dividend, req_divisor_m1, out_ready,
    input  req_ready, out_valid, out_quotient, out_id
  );

  // Divider block side.
  modport slave (
    input  req_valid, req_dividend, req_divisor_m1, out_ready,
    output req_ready, out_valid, out_quotient, out_id
  );
endinterface

// File: rtl/recip_lut_div_arbiter.sv
// Round-robin scheduler in front of one shared 8-bit reciprocal table.
// Each accepted request goes through three stages:
//   S1 holds the captured operands.
//   S2 holds the table lookup.
//   S3 holds the multiply, shift and bypass result.
// Every stage advances together when the output register is free or is being
// drained. Bubbles keep their slot while the pipeline is stalled.
module recip_lut_div_arbiter #(
  parameter int N_REQ = 4,
  parameter int DIV_W = 16,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  recip_lut_div_arbiter_if.slave bus
);

  // One extra bit so that ptr + offset can be wrapped without overflow.
  localparam int IDX_W = ID_W + 1;
  localparam logic [IDX_W-1:0] N_REQ_W = IDX_W'(N_REQ);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  ptr_next;
  logic             s1_valid_reg;
  logic             s2_valid_reg;
  logic             s3_valid_reg;

  // ---------------------------------------------------------------------
  // Datapath registers (no reset: qualified by the valid bits)
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] s1_dividend_reg;
  logic [7:0]       s1_k_reg;
  logic [ID_W-1:0]  s1_id_reg;

  logic [7:0]       s2_recip_reg;
  logic [DIV_W-1:0] s2_dividend_reg;
  logic             s2_bypass_reg;
  logic [ID_W-1:0]  s2_id_reg;

  logic [DIV_W-1:0] s3_quot_reg;
  logic [ID_W-1:0]  s3_id_reg;

  // ---------------------------------------------------------------------
  // Arbitration signals
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] dividend_arr   [N_REQ];
  logic [7:0]       divisor_m1_arr [N_REQ];
  logic [ID_W-1:0]  cand_id        [N_REQ];
  logic [N_REQ-1:0] cand_valid;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic             adv;
  logic             accept;

  // ---------------------------------------------------------------------
  // Reciprocal table: r(k) = floor(256/(k+1)), with r(0) = 255.
  // Entry 0 is never used arithmetically because k == 0 bypasses the
  // multiply. The saturated value only keeps the entry within 8 bits.
  // ---------------------------------------------------------------------
  logic [7:0]       recip_rom [256];

  logic [DIV_W+7:0] product;
  logic [DIV_W-1:0] scaled;

  genvar gi;

  // Unpack the flat per-requester operand buses into indexable arrays.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign dividend_arr[gi]   = bus.req_dividend[gi*DIV_W +: DIV_W];
      assign divisor_m1_arr[gi] = bus.req_divisor_m1[gi*8 +: 8];
    end
  endgenerate

  // Candidate gi is requester (ptr + gi) mod N_REQ. The search order
  // therefore starts at ptr. N_REQ need not be a power of two, so the wrap
  // is an explicit subtract.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W-1:0] raw_idx;
      assign raw_idx        = {1'b0, ptr_reg} + IDX_W'(gi);
      assign cand_id[gi]    = (raw_idx >= N_REQ_W) ? ID_W'(raw_idx - N_REQ_W)
                                                   : ID_W'(raw_idx);
      assign cand_valid[gi] = bus.req_valid[cand_id[gi]];
    end
  endgenerate

  // Constant table contents. This maps to a ROM / LUT block with a
  // registered read in S2.
  generate
    for (gi = 0; gi < 256; gi++) begin : g_rom
      if (gi == 0) begin : g_zero
        assign recip_rom[gi] = 8'd255;
      end else begin : g_div
        assign recip_rom[gi] = 8'(256 / (gi + 1));
      end
    end
  endgenerate

  // The first valid candidate in rotated order wins the grant.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!grant_found && cand_valid[j]) begin
        grant_found = 1'b1;
        grant_id    = cand_id[j];
      end
    end
  end

  // The pipeline moves only when the output slot is free or is being taken.
  // Reset gates the accept so that no request is consumed while rst_n is low.
  assign adv      = !s3_valid_reg || bus.out_ready;
  assign accept   = rst_n && adv && grant_found;
  assign ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

  // One-hot ready: only the granted lane, and only when its request can be taken.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = accept && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Full-width product. Taking the upper DIV_W bits of it is the >> 8.
  assign product = {8'd0, s2_dividend_reg} * {{DIV_W{1'b0}}, s2_recip_reg};
  assign scaled  = DIV_W'(product >> 8);

  // Valid bits and the round-robin pointer. They are cleared by reset and
  // frozen during a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      ptr_reg      <= '0;
    end else if (adv) begin
      s1_valid_reg <= accept;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      if (accept) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  // Datapath for the three stages. Bubble slots carry stale data, and their
  // cleared valid bits mask it.
  always_ff @(posedge clk) begin
    if (adv) begin
      // S1: capture the granted requester's operands.
      s1_dividend_reg <= dividend_arr[grant_id];
      s1_k_reg        <= divisor_m1_arr[grant_id];
      s1_id_reg       <= grant_id;
      // S2: registered table read, plus the divide-by-one bypass flag.
      s2_recip_reg    <= recip_rom[s1_k_reg];
      s2_dividend_reg <= s1_dividend_reg;
      s2_bypass_reg   <= (s1_k_reg == 8'd0);
      s2_id_reg       <= s1_id_reg;
      // S3: scaled product, or the exact dividend when the divisor is 1.
      s3_quot_reg     <= s2_bypass_reg ? s2_dividend_reg : scaled;
      s3_id_reg       <= s2_id_reg;
    end
  end

  assign bus.out_valid    = s3_valid_reg;
  assign bus.out_quotient = s3_quot_reg;
  assign bus.out_id       = s3_id_reg;

endmodule

// File: tb/tb_recip_lut_div_arbiter.sv
// Scoreboard bench for recip_lut_div_arbiter.
// On every accepted request, an acceptor process pushes the expected
// {id, quotient} onto a queue. A separate monitor process pops and compares
// the queue on every output handshake.
module tb_recip_lut_div_arbiter;
  localparam int N_REQ = 4;
  localparam int DIV_W = 16;
  localparam int ID_W  = 2;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [DIV_W-1:0] q;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  recip_lut_div_arbiter_if #(.N_REQ(N_REQ), .DIV_W(DIV_W), .ID_W(ID_W)) bus ();

  recip_lut_div_arbiter #(.N_REQ(N_REQ), .DIV_W(DIV_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             sb[$];
  int               grant_log[$];
  logic [DIV_W-1:0] exp_quot [N_REQ];
  int               n_vec      = 0;
  int               n_err      = 0;
  int               onehot_bad = 0;
  int               id2_seen   = 0;
  bit               id2_watch  = 1'b0;
  bit               verbose    = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DIV_W-1:0] d, input logic [7:0] k,
                         input logic [DIV_W-1:0] e);
    bus.req_dividend[i*DIV_W +: DIV_W] = d;
    bus.req_divisor_m1[i*8 +: 8]       = k;
    exp_quot[i]                        = e;
  endtask

  // Reference model used for the random phase.
  function automatic logic [DIV_W-1:0] ref_quot(input logic [DIV_W-1:0] d, input logic [7:0] k);
    int unsigned     r;
    longint unsigned p;
    if (k == 8'd0) return d;
    r = 256 / (int'(k) + 1);
    p = longint'(d) * longint'(r);
    return DIV_W'(p >> 8);
  endfunction

  // Present one request, wait (bounded) for its accept, then drop valid.
  task automatic issue(input int i, input logic [DIV_W-1:0] d, input logic [7:0] k,
                       input logic [DIV_W-1:0] e);
    logic got;
    got = 1'b0;
    set_req(i, d, k, e);
    bus.req_valid[i] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1'b1;
      tick();
    end
    bus.req_valid[i] = 1'b0;
    check("issue_accepted", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int c;
    bus.out_ready = 1'b1;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      tick();
      c++;
    end
    repeat (3) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  // Acceptor: every accepted request pushes its expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(bus.req_ready) > 1) onehot_bad++;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_t e;
          e.id = ID_W'(i);
          e.q  = exp_quot[i];
          sb.push_back(e);
          grant_log.push_back(i);
        end
      end
    end
  end

  // Monitor: every output handshake pops one entry and compares it.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (id2_watch && bus.out_id == 2'd2) id2_seen++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got id %0d q %0d, expected no result", bus.out_id,
                 bus.out_quotient);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (verbose)
          $display("result id=%0d q=%0d (expect id=%0d q=%0d)", bus.out_id, bus.out_quotient,
                   e.id, e.q);
        check("out_id", 32'(bus.out_id), 32'(e.id));
        check("out_quotient", 32'(bus.out_quotient), 32'(e.q));
      end
    end
  end

  // Watchdog: the run must always terminate.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int               lat;
    int               bad;
    int               mx;
    int               mn;
    int               cnt [N_REQ];
    logic [N_REQ-1:0] took;
    logic [DIV_W-1:0] d;
    logic [7:0]       k;

    bus.req_valid      = '0;
    bus.req_dividend   = '0;
    bus.req_divisor_m1 = '0;
    bus.out_ready      = 1'b1;
    for (int i = 0; i < N_REQ; i++) exp_quot[i] = '0;

    // Reset with every requester asserting valid: nothing may be accepted.
    rst_n         = 1'b0;
    bus.req_valid = '1;
    repeat (2) tick();
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.req_valid = '0;
    rst_n         = 1'b1;
    tick();

    // Single request and its latency: 1000 / 4 gives 250 three cycles after the accept.
    issue(0, 16'd1000, 8'd3, 16'd250);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check("latency_cycles", lat, 3);
    tick();

    // Directed vectors and boundaries. The last one is requester 3, so ptr returns to 0.
    issue(1, 16'd300,   8'd2,   16'd99);
    issue(0, 16'd1000,  8'd0,   16'd1000);
    issue(2, 16'd65535, 8'd1,   16'd32767);
    issue(1, 16'd0,     8'd77,  16'd0);
    issue(0, 16'd65535, 8'd0,   16'd65535);
    issue(2, 16'd5000,  8'd4,   16'd996);
    issue(3, 16'd65535, 8'd255, 16'd255);
    drain();

    // Round-robin: all four requesters valid for 40 cycles.
    grant_log.delete();
    for (int i = 0; i < N_REQ; i++) set_req(i, 16'(100 * (i + 1)), 8'd0, 16'(100 * (i + 1)));
    bus.req_valid = '1;
    repeat (40) begin
      @(negedge clk);
      tick();
    end
    bus.req_valid = '0;
    check("rr_grant_count", grant_log.size(), 40);
    bad = 0;
    for (int n = 0; n < grant_log.size(); n++) if (grant_log[n] != n % N_REQ) bad++;
    check("rr_order_errors", bad, 0);
    for (int i = 0; i < N_REQ; i++) cnt[i] = 0;
    foreach (grant_log[n]) cnt[grant_log[n]]++;
    mx = cnt[0];
    mn = cnt[0];
    for (int i = 1; i < N_REQ; i++) begin
      if (cnt[i] > mx) mx = cnt[i];
      if (cnt[i] < mn) mn = cnt[i];
    end
    check("rr_spread_within_1", 32'(mx - mn <= 1), 32'd1);
    drain();

    // Back-pressure: three accepts, a 5-cycle stall, a withdrawn request from 2, then release.
    id2_watch = 1'b1;
    id2_seen  = 0;
    set_req(0, 16'd1234, 8'd3,  16'd308);
    set_req(1, 16'd777,  8'd6,  16'd109);
    set_req(2, 16'd4096, 8'd15, 16'd256);
    bus.req_valid = 4'b0111;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_grant", 32'(bus.req_ready), 32'(1 << j));
      tick();
      bus.req_valid[j] = 1'b0;
    end
    bus.out_ready = 1'b0;
    set_req(3, 16'd900, 8'd8, 16'd98);
    bus.req_valid[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_out_id", 32'(bus.out_id), 32'd0);
      check("stall_out_quotient", 32'(bus.out_quotient), 32'd308);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      if (c == 0) begin
        set_req(2, 16'd5555, 8'd0, 16'd5555);
        bus.req_valid[2] = 1'b1;
      end
      if (c == 1) bus.req_valid[2] = 1'b0;
      if (c == 4) bus.out_ready = 1'b1;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("release_out_valid", 32'(bus.out_valid), 32'd1);
      check("release_out_id", 32'(bus.out_id), 32'(j));
      if (j == 0) check("release_resume_grant", 32'(bus.req_ready), 32'b1000);
      tick();
      if (j == 0) bus.req_valid[3] = 1'b0;
    end
    drain();
    id2_watch = 1'b0;
    check("withdrawn_id2_outputs", id2_seen, 1);

    // Reset mid-operation: three results in flight with ptr at 3, then a pulse.
    set_req(0, 16'd10, 8'd0, 16'd10);
    set_req(1, 16'd20, 8'd0, 16'd20);
    set_req(2, 16'd30, 8'd0, 16'd30);
    bus.req_valid = 4'b0111;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      tick();
      bus.req_valid[j] = 1'b0;
    end
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    set_req(0, 16'd400,   8'd1,   16'd200);
    set_req(1, 16'd900,   8'd2,   16'd298);
    set_req(2, 16'd1024,  8'd7,   16'd128);
    set_req(3, 16'd12345, 8'd255, 16'd48);
    bus.req_valid = '1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("post_reset_grant", 32'(bus.req_ready), 32'(1 << j));
      tick();
    end
    bus.req_valid = '0;
    drain();

    // Random valid/ready traffic against the reference model.
    verbose = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      took = bus.req_valid & bus.req_ready;
      tick();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && !took[i]) begin
          if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       d = '0;
            1:       d = '1;
            default: d = DIV_W'($urandom);
          endcase
          case ($urandom_range(0, 4))
            0:       k = 8'd0;
            1:       k = 8'd255;
            2:       k = 8'd1;
            default: k = 8'($urandom);
          endcase
          set_req(i, d, k, ref_quot(d, k));
          bus.req_valid[i] = 1'b1;
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.req_valid = '0;
    drain();
    check("req_ready_onehot_violations", onehot_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
